// File: rtl/v850_seq_ctrl.sv
// Multi-cycle instruction sequencer for the V850 core: FETCH/DECODE/EXEC/MEM/WB stepping,
// program counter ownership, EI-level interrupt entry and HALT/illegal-stop handling.
module v850_seq_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EI_BASE      = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  output logic        dec_en,
  input  logic [1:0]  dec_len,
  input  logic        dec_mem,
  input  logic        dec_halt,
  output logic        exe_en,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic        wb_en,
  input  logic        ei_req,
  input  logic [7:0]  ei_code,
  input  logic        psw_id,
  input  logic        psw_np,
  output logic        ei_ack,
  output logic        eipc_we,
  output logic        eipsw_we,
  output logic [31:0] eipc_o,
  output logic        psw_id_set,
  output logic [31:0] pc,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [3:0] {
    ST_RST, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_EXC, ST_HALT, ST_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [25:1] pc_q;
  logic [25:1] npc_q;
  logic [1:0]  len_q;
  logic        mem_q;
  logic        halt_q;
  logic        illegal_q;

  logic        int_ok;
  logic [2:0]  step_units;
  logic [25:0] seq_pc;
  logic [25:0] vec_pc;
  logic        unused_bits;

  assign int_ok     = ei_req & ~psw_id & ~psw_np;
  assign step_units = {1'b0, len_q} + 3'd1;
  // Only 26 address bits exist; the increment wraps there and bit 25 sign-extends.
  assign seq_pc     = {pc_q, 1'b0} + {22'd0, step_units, 1'b0};
  assign vec_pc     = EI_BASE[25:0] + {14'd0, ei_code, 4'b0000};
  assign unused_bits = ^{br_target[31:26], br_target[0], seq_pc[0], vec_pc[0]};

  assign pc         = {{6{pc_q[25]}}, pc_q, 1'b0};
  assign fetch_addr = pc;
  assign illegal    = illegal_q;

  // NOTE: every output and state_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    fetch_req  = 1'b0;
    dec_en     = 1'b0;
    exe_en     = 1'b0;
    mem_req    = 1'b0;
    wb_en      = 1'b0;
    ei_ack     = 1'b0;
    eipc_we    = 1'b0;
    eipsw_we   = 1'b0;
    psw_id_set = 1'b0;
    eipc_o     = 32'd0;
    halted     = 1'b0;
    unique case (state_q)
      ST_RST:    state_d = ST_FETCH;
      ST_FETCH: begin
        fetch_req = 1'b1;
        if (fetch_ack) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        dec_en  = 1'b1;
        state_d = (dec_len == 2'd3) ? ST_STOP : ST_EXEC;
      end
      ST_EXEC: begin
        exe_en  = 1'b1;
        state_d = mem_q ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = ST_WB;
      end
      ST_WB: begin
        wb_en = 1'b1;
        if (int_ok)      state_d = ST_EXC;
        else if (halt_q) state_d = ST_HALT;
        else             state_d = ST_FETCH;
      end
      ST_EXC: begin
        ei_ack     = 1'b1;
        eipc_we    = 1'b1;
        eipsw_we   = 1'b1;
        psw_id_set = 1'b1;
        eipc_o     = pc;
        state_d    = ST_FETCH;
      end
      ST_HALT: begin
        halted = 1'b1;
        if (int_ok) state_d = ST_EXC;
      end
      ST_STOP:   halted = 1'b1;
      default:   state_d = ST_RST;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST;
      pc_q      <= RESET_VECTOR[25:1];
      npc_q     <= RESET_VECTOR[25:1];
      len_q     <= 2'd0;
      mem_q     <= 1'b0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_DECODE: begin
          len_q  <= dec_len;
          mem_q  <= dec_mem;
          halt_q <= dec_halt;
          if (dec_len == 2'd3) illegal_q <= 1'b1;
        end
        ST_EXEC: npc_q <= br_taken ? br_target[25:1] : seq_pc[25:1];
        ST_WB:   pc_q  <= npc_q;
        ST_EXC:  pc_q  <= vec_pc[25:1];
        default: ;
      endcase
    end
  end

endmodule
